// File: rtl/deco_p_pkg.sv
// Shared types and helpers for the sequential 3:8 decoder (deco_p_seq).
package deco_p_pkg;

  localparam int unsigned IDX_W_DEF = 3;
  localparam int unsigned OH_W_DEF  = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } deco_st_e;

  function automatic logic [OH_W_DEF-1:0] onehot_of(input logic [IDX_W_DEF-1:0] idx);
    return OH_W_DEF'(1) << idx;
  endfunction

endpackage

// File: rtl/deco_p_chk.sv
// Round-trip checker: re-encodes the held one-hot word and compares it with the accepted index.
// Only compiled when DECO_P_ROUNDTRIP_CHK_EN is defined.
`ifdef DECO_P_ROUNDTRIP_CHK_EN
module deco_p_chk
  import deco_p_pkg::*;
#(
  parameter  int unsigned IDX_W = IDX_W_DEF,
  localparam int unsigned OH_W  = 2**IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [OH_W-1:0]  onehot,
  input  logic [IDX_W-1:0] idx,
  output logic             chk_err
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [IDX_W-1:0] enc;
  logic [CNT_W-1:0] pop;
  logic             chk_err_q;
  logic             chk_err_d;

  // Priority re-encode (highest set bit wins) plus population count.
  always_comb begin
    enc = '0;
    pop = '0;
    for (int i = 0; i < int'(OH_W); i++) begin
      if (onehot[i]) enc = IDX_W'(i);
      pop = pop + CNT_W'(onehot[i]);
    end
    chk_err_d = chk_err_q | (valid & ((enc != idx) | (pop != CNT_W'(1))));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_err_q <= 1'b0;
    else        chk_err_q <= chk_err_d;
  end

  assign chk_err = chk_err_q;

endmodule
`endif

// File: rtl/deco_p_seq.sv
// Sequential 3:8 decoder with 1-deep registered output, sticky pending bitmap and overflow flag.
// Optional round-trip checker enabled by DECO_P_ROUNDTRIP_CHK_EN.
module deco_p_seq
  import deco_p_pkg::*;
#(
  parameter  int unsigned        IDX_W    = IDX_W_DEF,
  localparam int unsigned        OH_W     = 2**IDX_W,
  parameter  logic [OH_W-1:0]    PEND_RST = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OH_W-1:0]  out_onehot,
  input  logic             out_ready,
  output logic [OH_W-1:0]  pend,
  input  logic [OH_W-1:0]  clr_mask,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic             chk_err
);

  deco_st_e        state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [OH_W-1:0] out_onehot_q, out_onehot_d;
  logic [OH_W-1:0] pend_q, pend_d;
  logic            ovf_q, ovf_d;
  logic            accept;
  logic [OH_W-1:0] set_vec;

  // Stage frees up when empty or when the held word leaves this cycle.
  assign in_ready = (state_q == EMPTY) | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_onehot_d = out_onehot_q;
    set_vec      = '0;
    if (accept) set_vec = OH_W'(1) << in_idx;

    if (accept) begin
      state_d      = FULL;
      out_valid_d  = 1'b1;
      out_onehot_d = set_vec;
    end else if ((state_q == FULL) && out_ready) begin
      state_d      = EMPTY;
      out_valid_d  = 1'b0;
      out_onehot_d = '0;
    end

    // Set wins over clear; a re-hit counts only if the bit is not being cleared.
    pend_d = (pend_q & ~clr_mask) | set_vec;
    ovf_d  = (ovf_q & ~ovf_clr) | (accept & pend_q[in_idx] & ~clr_mask[in_idx]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      out_valid_q  <= 1'b0;
      out_onehot_q <= '0;
      pend_q       <= PEND_RST;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_onehot_q <= out_onehot_d;
      pend_q       <= pend_d;
      ovf_q        <= ovf_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_onehot = out_onehot_q;
  assign pend       = pend_q;
  assign ovf        = ovf_q;

`ifdef DECO_P_ROUNDTRIP_CHK_EN
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;

  assign idx_d = accept ? in_idx : idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= '0;
    else        idx_q <= idx_d;
  end

  deco_p_chk #(.IDX_W(IDX_W)) u_chk (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (out_valid_q),
    .onehot  (out_onehot_q),
    .idx     (idx_q),
    .chk_err (chk_err)
  );
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_deco_p_seq.sv
// Directed self-checking bench for deco_p_seq.
module tb_deco_p_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_idx;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_onehot;
  logic       out_ready;
  logic [7:0] pend;
  logic [7:0] clr_mask;
  logic       ovf;
  logic       ovf_clr;
  logic       chk_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  deco_p_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_idx     (in_idx),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_onehot (out_onehot),
    .out_ready  (out_ready),
    .pend       (pend),
    .clr_mask   (clr_mask),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .chk_err    (chk_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [2:0] sidx [5];
  logic [7:0] soh  [5];

  initial begin
    sidx = '{3'd7, 3'd6, 3'd0, 3'd5, 3'd3};
    soh  = '{8'h80, 8'h40, 8'h01, 8'h20, 8'h08};

    // Reset held with a request already presented
    rst_n = 1'b0; in_valid = 1'b1; in_idx = 3'd6; out_ready = 1'b1;
    clr_mask = 8'h00; ovf_clr = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", {7'd0, out_valid}, 8'h00);
    check("rst_onehot", out_onehot, 8'h00);
    check("rst_pend", pend, 8'h00);
    check("rst_ovf", {7'd0, ovf}, 8'h00);
    check("rst_chk_err", {7'd0, chk_err}, 8'h00);
    tick();
    check("first_valid", {7'd0, out_valid}, 8'h01);
    check("first_onehot", out_onehot, 8'h40);

    in_valid = 1'b0; clr_mask = 8'hFF;
    tick();
    clr_mask = 8'h00;
    check("drain_valid", {7'd0, out_valid}, 8'h00);
    check("drain_onehot", out_onehot, 8'h00);
    check("drain_pend", pend, 8'h00);

    // Back-to-back stream
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_idx = sidx[i];
      #1;
      check("stream_in_ready", {7'd0, in_ready}, 8'h01);
      tick();
      check("stream_valid", {7'd0, out_valid}, 8'h01);
      check("stream_onehot", out_onehot, soh[i]);
    end
    check("stream_pend", pend, 8'hE9);
    check("stream_ovf", {7'd0, ovf}, 8'h00);
    in_valid = 1'b0;
    tick();
    check("stream_end_valid", {7'd0, out_valid}, 8'h00);

    // Stall
    in_valid = 1'b1; in_idx = 3'd2;
    tick();
    check("stall_first", out_onehot, 8'h04);
    out_ready = 1'b0; in_idx = 3'd4;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_in_ready", {7'd0, in_ready}, 8'h00);
      tick();
      check("stall_hold", out_onehot, 8'h04);
      check("stall_valid", {7'd0, out_valid}, 8'h01);
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", {7'd0, in_ready}, 8'h01);
    tick();
    check("unstall_onehot", out_onehot, 8'h10);
    check("unstall_pend", pend, 8'hFD);
    in_valid = 1'b0;
    tick();

    // Overflow
    clr_mask = 8'hFF; in_valid = 1'b1; in_idx = 3'd3;
    tick();
    check("ovf_setup_pend", pend, 8'h08);
    check("ovf_setup_ovf", {7'd0, ovf}, 8'h00);
    clr_mask = 8'h00;
    tick();
    check("ovf_hit", {7'd0, ovf}, 8'h01);
    in_valid = 1'b0; ovf_clr = 1'b1;
    tick();
    check("ovf_clr", {7'd0, ovf}, 8'h00);
    ovf_clr = 1'b0; clr_mask = 8'h08; in_valid = 1'b1; in_idx = 3'd3;
    tick();
    check("ovf_masked", {7'd0, ovf}, 8'h00);
    check("ovf_masked_pend", pend, 8'h08);
    clr_mask = 8'h00; ovf_clr = 1'b1;
    tick();
    check("ovf_hit_beats_clr", {7'd0, ovf}, 8'h01);
    in_valid = 1'b0;
    tick();
    check("ovf_clr2", {7'd0, ovf}, 8'h00);
    ovf_clr = 1'b0;

    // Clear race
    in_valid = 1'b1; in_idx = 3'd1; clr_mask = 8'hFF;
    tick();
    check("race_pend", pend, 8'h02);
    check("race_onehot", out_onehot, 8'h02);

    // Unknown index while idle
    in_valid = 1'b0; in_idx = 3'bxxx; clr_mask = 8'h00;
    tick();
    check("x_pend", pend, 8'h02);
    check("x_valid", {7'd0, out_valid}, 8'h00);
    check("x_onehot", out_onehot, 8'h00);
    tick();
    check("x_pend2", pend, 8'h02);
    check("x_ovf", {7'd0, ovf}, 8'h00);

    // Reset mid-transfer
    in_valid = 1'b1; in_idx = 3'd5; out_ready = 1'b0;
    tick();
    check("mid_valid", {7'd0, out_valid}, 8'h01);
    check("mid_onehot", out_onehot, 8'h20);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {7'd0, out_valid}, 8'h00);
    check("mid_rst_onehot", out_onehot, 8'h00);
    check("mid_rst_pend", pend, 8'h00);
    in_valid = 1'b0; out_ready = 1'b1; in_idx = 3'd0;
    tick();
    rst_n = 1'b1;
    tick();

`ifdef DECO_P_ROUNDTRIP_CHK_EN
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_idx = 3'(i);
      tick();
      check("chk_onehot", out_onehot, 8'h01 << i);
      check("chk_clean", {7'd0, chk_err}, 8'h00);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    force dut.out_onehot_q = 8'h0C;
    tick(); tick();
    release dut.out_onehot_q;
    check("chk_err_set", {7'd0, chk_err}, 8'h01);
    out_ready = 1'b1;
    tick(); tick();
    check("chk_err_sticky", {7'd0, chk_err}, 8'h01);
`else
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_idx = 3'(i);
      tick();
      check("nochk_onehot", out_onehot, 8'h01 << i);
      check("nochk_err", {7'd0, chk_err}, 8'h00);
    end
    in_valid = 1'b0;
    tick();
    check("nochk_err_end", {7'd0, chk_err}, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
